// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the heap memory read/cons ports between NumReq requesters, one op at a time.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed lowest-id-wins priority.
module mem_arbiter #(
    parameter int NumReq = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NumReq-1:0]    req_valid,
    input  logic [NumReq-1:0]    req_cons,
    input  logic [NumReq*12-1:0] req_addr,
    input  logic [NumReq*16-1:0] req_car,
    input  logic [NumReq*16-1:0] req_cdr,
    output logic [NumReq-1:0]    rsp_valid,
    output logic [15:0]          rsp_data,
    output logic                 busy,
    output logic                 mem_req,
    output logic [11:0]          mem_addr,
    input  logic                 mem_data_ready,
    input  logic [15:0]          mem_data,
    output logic                 mem_cons_en,
    output logic [15:0]          mem_cons_car,
    output logic [15:0]          mem_cons_cdr,
    input  logic                 mem_cons_done,
    input  logic [15:0]          mem_cons_ptr
);
    localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_CONS, RESP} state_t;

    state_t         state, state_nx;
    logic [IdW-1:0] id, win;
    logic           win_ok, cons_q, sel_cons;
    logic [11:0]    sel_addr;
    logic [15:0]    sel_car, sel_cdr;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IdW-1:0] rr_last, idx;
`endif

    // Candidates are visited from lowest to highest priority so the best one is written last.
    always_comb begin
        win = '0;
        win_ok = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_valid[IdW'(i)]) begin
                win = IdW'(i);
                win_ok = 1'b1;
            end
        end
`else
        idx = '0;
        for (int k = NumReq; k >= 1; k--) begin
            idx = IdW'((int'(rr_last) + k) % NumReq);
            if (req_valid[idx]) begin
                win = idx;
                win_ok = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        sel_cons = 1'b0;
        sel_addr = '0;
        sel_car = '0;
        sel_cdr = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (win == IdW'(i)) begin
                sel_cons = req_cons[IdW'(i)];
                sel_addr = req_addr[12*i +: 12];
                sel_car = req_car[16*i +: 16];
                sel_cdr = req_cdr[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = win_ok ? ISSUE : IDLE;
            ISSUE:     state_nx = cons_q ? WAIT_CONS : WAIT_RD;
            WAIT_RD:   state_nx = mem_data_ready ? RESP : WAIT_RD;
            WAIT_CONS: state_nx = mem_cons_done ? RESP : WAIT_CONS;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        busy = state != IDLE;
        mem_req = state == ISSUE && !cons_q;
        mem_cons_en = state == ISSUE && cons_q;
        rsp_valid = '0;
        for (int i = 0; i < NumReq; i++) begin
            rsp_valid[IdW'(i)] = state == RESP && id == IdW'(i);
        end
    end

    // The payload is captured once at grant; mem_* ports hold it until the next grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            id <= '0;
            cons_q <= 1'b0;
            mem_addr <= '0;
            mem_cons_car <= '0;
            mem_cons_cdr <= '0;
            rsp_data <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_last <= IdW'(NumReq - 1);
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && win_ok) begin
                id <= win;
                cons_q <= sel_cons;
                mem_addr <= sel_addr;
                mem_cons_car <= sel_car;
                mem_cons_cdr <= sel_cdr;
`ifndef MEM_ARB_FIXED_PRIO_EN
                rr_last <= win;
`endif
            end
            if (state == WAIT_RD && mem_data_ready) rsp_data <= mem_data;
            if (state == WAIT_CONS && mem_cons_done) rsp_data <= mem_cons_ptr;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model.
// Honours MEM_ARB_FIXED_PRIO_EN the same way as the design.
module tb_mem_arbiter;
    localparam int N = 2;
    localparam logic [15:0] HEAP_BASE = 16'd5;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_cons = '0;
    logic [N*12-1:0] req_addr = '0;
    logic [N*16-1:0] req_car = '0, req_cdr = '0;
    logic [N-1:0] rsp_valid;
    logic [15:0] rsp_data;
    logic busy, mem_req, mem_cons_en;
    logic [11:0] mem_addr;
    logic mem_data_ready = 1'b0, mem_cons_done = 1'b0;
    logic [15:0] mem_data = '0, mem_cons_ptr = '0, mem_cons_car, mem_cons_cdr;

    always #5 clk = ~clk;

    mem_arbiter #(.NumReq(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cons(req_cons),
        .req_addr(req_addr), .req_car(req_car), .req_cdr(req_cdr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
        .mem_cons_en(mem_cons_en), .mem_cons_car(mem_cons_car), .mem_cons_cdr(mem_cons_cdr),
        .mem_cons_done(mem_cons_done), .mem_cons_ptr(mem_cons_ptr)
    );

    logic [15:0] mem [0:4095];
    int checks = 0, errors = 0, cyc = 0;
    // transaction-level model of the arbiter
    bit inflight = 0, wcons = 0;
    int grant_c = 0, rsp_c = 0, free_c = 0, rr = N - 1, wid = 0, ncons = 0;
    logic [15:0] wdata = '0, last = '0, lat_car = '0, lat_cdr = '0;
    logic [11:0] lat_addr = '0;
    bit [N-1:0] granted = '0;
    int served [N];
    // memory environment
    int rd_at = -1, cons_at = -1, mcons = 0;
    logic [11:0] rd_addr = '0;
    bit spur_force = 0, rand_mode = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int lst);
        if (FIXED) begin
            for (int k = 0; k < N; k++) if (v[k]) return k;
        end else begin
            for (int k = 1; k <= N; k++) if (v[(lst + k) % N]) return (lst + k) % N;
        end
        return 0;
    endfunction

    task automatic set_req(int i, bit c, logic [11:0] a, logic [15:0] car, logic [15:0] cdr);
        req_valid[i] = 1'b1;
        req_cons[i] = c;
        req_addr[12*i +: 12] = a;
        req_car[16*i +: 16] = car;
        req_cdr[16*i +: 16] = cdr;
    endtask

    task automatic scramble(int i);
        req_cons[i] = 1'($urandom);
        req_addr[12*i +: 12] = 12'($urandom);
        req_car[16*i +: 16] = 16'($urandom);
        req_cdr[16*i +: 16] = 16'($urandom);
    endtask

    task automatic step();
        logic [N-1:0] ev;
        if (!rst_n) begin
            inflight = 0; free_c = 0; rr = N - 1; last = '0; ncons = 0; granted = '0;
            lat_addr = '0; lat_car = '0; lat_cdr = '0;
            rd_at = -1; cons_at = -1; mcons = 0;
        end else if (cyc >= free_c && |req_valid) begin
            wid = pick(req_valid, rr);
            rr = wid;
            wcons = req_cons[wid];
            lat_addr = req_addr[12*wid +: 12];
            lat_car = req_car[16*wid +: 16];
            lat_cdr = req_cdr[16*wid +: 16];
            if (wcons) ncons++;
            wdata = wcons ? HEAP_BASE + 16'(ncons) : mem[lat_addr];
            grant_c = cyc;
            rsp_c = cyc + (wcons ? 4 : 3);
            free_c = rsp_c + 1;
            inflight = 1;
            granted[wid] = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        ev = '0;
        if (inflight && cyc == rsp_c) begin
            ev[wid] = 1'b1;
            last = wdata;
        end
        check("rsp_valid", rsp_valid, ev);
        check("rsp_data", rsp_data, last);
        check("busy", busy, inflight && cyc > grant_c);
        check("mem_req", mem_req, inflight && cyc == grant_c + 1 && !wcons);
        check("mem_cons_en", mem_cons_en, inflight && cyc == grant_c + 1 && wcons);
        check("mem_addr", mem_addr, lat_addr);
        check("mem_cons_car", mem_cons_car, lat_car);
        check("mem_cons_cdr", mem_cons_cdr, lat_cdr);
        if (ev != '0) begin
            inflight = 0;
            granted[wid] = 1'b0;
        end
        for (int i = 0; i < N; i++) if (rsp_valid[i]) served[i]++;
        // memory: read data one cycle after the strobe, cons done two cycles after
        mem_data_ready = cyc == rd_at;
        mem_data = (cyc == rd_at) ? mem[rd_addr] : 16'($urandom);
        mem_cons_done = cyc == cons_at;
        mem_cons_ptr = (cyc == cons_at) ? HEAP_BASE + 16'(mcons) : 16'($urandom);
        if (!inflight && (spur_force || (rand_mode && $urandom_range(7) == 0))) begin
            mem_data_ready = 1'b1;
            mem_cons_done = spur_force ? 1'b1 : 1'($urandom);
        end
        if (mem_req) begin
            rd_at = cyc + 1;
            rd_addr = mem_addr;
        end
        if (mem_cons_en) begin
            mcons++;
            cons_at = cyc + 2;
        end
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i]) req_valid[i] = 1'b0;
            else if (rand_mode) begin
                if (granted[i]) scramble(i);
                else if (!req_valid[i] && $urandom_range(3) == 0) begin
                    scramble(i);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(15) == 0) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_rsp(int i, int tmo, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!rsp_valid[i] && lat < tmo);
        check("rsp_timeout", rsp_valid[i], 1);
    endtask

    initial begin
        int lat, n, b;
        logic [11:0] a;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[1] = 16'hBEEF;
        for (int i = 0; i < N; i++) served[i] = 0;
        // reset
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        // single read
        set_req(0, 1'b0, 12'h001, 16'h0, 16'h0);
        wait_rsp(0, 10, lat);
        check("rd_latency", lat, 3);
        check("rd_data", rsp_data, 16'hBEEF);
        step();
        // single cons
        set_req(1, 1'b1, 12'h000, 16'h0002, 16'h0001);
        wait_rsp(1, 10, lat);
        check("cons_latency", lat, 4);
        check("cons_ptr", rsp_data, 16'd6);
        step();
        // withdrawn pulse during an op, then spurious memory strobes while idle
        b = served[1];
        a = 12'($urandom);
        set_req(0, 1'b0, a, 16'h0, 16'h0);
        step();
        req_valid[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        wait_rsp(0, 10, lat);
        check("withdraw_rd_data", rsp_data, mem[a]);
        spur_force = 1;
        step();
        spur_force = 0;
        repeat (4) step();
        check("withdraw_served", served[1] - b, 0);
        check("spurious_busy", busy, 0);
        // reset in WAIT_CONS, then a fresh read
        set_req(1, 1'b1, 12'h0, 16'h1234, 16'h5678);
        step();
        step();
        check("cons_wait_busy", busy, 1);
        rst_n = 1'b0;
        req_valid = '0;
        step();
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        repeat (3) step();
        a = 12'($urandom);
        set_req(0, 1'b0, a, 16'h0, 16'h0);
        wait_rsp(0, 10, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_data", rsp_data, mem[a]);
        step();
        // contention from a fresh reset
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        set_req(0, 1'b0, 12'($urandom), 16'h0, 16'h0);
        set_req(1, 1'b0, 12'($urandom), 16'h0, 16'h0);
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (rsp_valid == '0 && n < 20);
            check("contention_rsp", |rsp_valid, 1);
            check("grant_order", rsp_valid[1] ? 1 : 0, FIXED ? 0 : k % 2);
            if (rsp_valid[0]) set_req(0, 1'b0, 12'($urandom), 16'h0, 16'h0);
            else if (rsp_valid[1]) set_req(1, 1'b0, 12'($urandom), 16'h0, 16'h0);
        end
        req_valid = '0;
        repeat (6) step();
        // randomized traffic
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        for (int i = 0; i < N; i++) if (!granted[i]) req_valid[i] = 1'b0;
        n = 0;
        while ((inflight || |req_valid) && n < 50) begin
            step();
            n++;
        end
        check("drain_done", inflight || |req_valid, 0);
        step();
        check("final_busy", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
